// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, bus event bit
// positions and the default own address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_DATA   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_DATA   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  localparam int EV_W        = 4;
  localparam int EV_SCL_RISE = 0;
  localparam int EV_SCL_FALL = 1;
  localparam int EV_START    = 2;
  localparam int EV_STOP     = 3;

  typedef logic [EV_W-1:0] ev_t;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h42;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
    return addr_byte[7:1] == own_addr;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, optional 3-sample majority filter (I2C_SLAVE_FILTER_EN)
// and registered SCL edge / START / STOP detection.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output ev_t  ev_o
);

  logic [1:0] line_raw;
  logic [1:0] lvl;
  logic [1:0] prev_q;
  ev_t        ev_d;
  ev_t        ev_q;

  // bit 0 carries SCL, bit 1 carries SDA
  assign line_raw = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic sync1_q;
      logic sync2_q;

      // Reset to the idle-high bus level so no edge is seen on release.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
        end else begin
          sync1_q <= line_raw[gi];
          sync2_q <= sync1_q;
        end
      end

`ifdef I2C_SLAVE_FILTER_EN
      logic [1:0] hist_q;
      logic       filt_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          hist_q <= 2'b11;
          filt_q <= 1'b1;
        end else begin
          hist_q <= {hist_q[0], sync2_q};
          filt_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
      end

      assign lvl[gi] = filt_q;
`else
      assign lvl[gi] = sync2_q;
`endif
    end
  endgenerate

  always_comb begin
    ev_d              = '0;
    ev_d[EV_SCL_RISE] = lvl[0] & ~prev_q[0];
    ev_d[EV_SCL_FALL] = ~lvl[0] & prev_q[0];
    ev_d[EV_START]    = lvl[0] & prev_q[0] & prev_q[1] & ~lvl[1];
    ev_d[EV_STOP]     = lvl[0] & prev_q[0] & ~prev_q[1] & lvl[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 2'b11;
      ev_q   <= '0;
    end else begin
      prev_q <= lvl;
      ev_q   <= ev_d;
    end
  end

  // prev_q[1] is the SDA level aligned with the registered events.
  assign sda_lvl_o = prev_q[1];
  assign ev_o      = ev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: fixed 7-bit address, byte receive on writes, byte
// transmit on reads, open-drain SDA. Glitch filter enabled by I2C_SLAVE_FILTER_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

  ev_t        ev;
  logic       sda_lvl;
  logic       sda_oe;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       ack_hi_q, ack_hi_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_lvl_o (sda_lvl),
    .ev_o      (ev)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      ack_hi_q   <= 1'b0;
      sda_low_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_hi_q   <= ack_hi_d;
      sda_low_q  <= sda_low_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_hi_d   = ack_hi_q;
    sda_low_d  = sda_low_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;

    // START/STOP take priority over any SCL edge in the same cycle.
    if (ev[EV_START]) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      ack_hi_d  = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (ev[EV_STOP]) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      ack_hi_d  = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (ev[EV_SCL_RISE]) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (addr_match({shift_q[6:0], sda_lvl}, ADDRESS)) begin
                state_d  = ST_ADDR_ACK;
                rw_d     = sda_lvl;
                ack_hi_d = 1'b0;
                busy_d   = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // First fall after the byte asserts ACK, the next one ends the ACK clock.
        ST_ADDR_ACK, ST_RX_ACK: begin
          if (ev[EV_SCL_FALL]) begin
            if (!ack_hi_q) begin
              ack_hi_d  = 1'b1;
              sda_low_d = 1'b1;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                shift_d   = tx_data;
                tx_load_d = 1'b1;
              end
            end else begin
              ack_hi_d  = 1'b0;
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                // First data bit goes out on this same fall.
                state_d   = ST_TX_DATA;
                sda_low_d = ~shift_q[7];
                shift_d   = {shift_q[6:0], 1'b0};
                bit_cnt_d = 4'd1;
              end else begin
                state_d = ST_RX_DATA;
              end
            end
          end
        end

        ST_RX_DATA: begin
          if (ev[EV_SCL_RISE]) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = '0;
              rx_data_d  = {shift_q[6:0], sda_lvl};
              rx_valid_d = 1'b1;
              ack_hi_d   = 1'b0;
              state_d    = ST_RX_ACK;
            end
          end
        end

        ST_TX_DATA: begin
          if (ev[EV_SCL_FALL]) begin
            if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_TX_ACK;
            end else begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_TX_ACK: begin
          if (ev[EV_SCL_RISE]) begin
            if (!sda_lvl) begin
              shift_d   = tx_data;
              tx_load_d = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_TX_DATA;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_comb begin
    // Reset releases the line combinationally, not one edge later.
    sda_oe   = sda_low_q & ~reset;
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    tx_load  = tx_load_q;
    busy     = busy_q;
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master drives writes, reads,
// repeated START, mid-transfer reset and (with the filter build) an SCL glitch.
module tb_i2c_slave;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;

  logic [7:0] tx_vals [0:3] = '{8'h3C, 8'hC3, 8'h96, 8'h00};
  int         tx_idx = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         drv_cnt = 0;
  int         run_len = 0;
  int         max_run = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda     = m_sda_low ? 1'b0 : 1'bz;
  assign tx_data = tx_vals[tx_idx];

  i2c_slave #(.ADDRESS(7'h42)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (tx_load) begin
      tx_cnt <= tx_cnt + 1;
      if (tx_idx < 3) tx_idx <= tx_idx + 1;
    end
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      run_len <= run_len + 1;
      if (run_len + 1 > max_run) max_run <= run_len + 1;
    end else begin
      run_len <= 0;
    end
    if (sda === 1'b0 && !m_sda_low) drv_cnt <= drv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q(input int n);
    repeat (10 * n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; q(1);
    scl = 1'b1;       q(1);
    m_sda_low = 1'b1; q(1);
    scl = 1'b0;       q(1);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; q(1);
    scl = 1'b1;       q(1);
    m_sda_low = 1'b0; q(2);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    m_sda_low = ~b; q(1);
    scl = 1'b1;     q(1);
    if (glitch) begin
      scl = 1'b0; @(negedge clk);
      scl = 1'b1; @(negedge clk);
    end
    q(1);
    scl = 1'b0;     q(1);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; q(1);
    scl = 1'b1;       q(1);
    b = sda;          q(1);
    scl = 1'b0;       q(1);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic master_nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(master_nack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         rx_base, tx_base, drv_base;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_sda", {31'd0, sda}, 32'd1);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_load", {31'd0, tx_load}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    q(2);

    // Write 0x84 then 0xA5
    rx_base = rx_cnt;
    bus_start();
    write_byte(8'h84, -1, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'hA5, -1, ack);
    check("wr_data_ack", {31'd0, ack}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd1);
    bus_stop();
    check("wr_rx_count", rx_cnt - rx_base, 32'd1);
    check("wr_rx_data", {24'd0, rx_data}, 32'hA5);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    check("rx_valid_width", max_run, 32'd1);

    // Foreign address 0x43
    rx_base  = rx_cnt;
    drv_base = drv_cnt;
    bus_start();
    write_byte(8'h86, -1, ack);
    check("nomatch_ack", {31'd0, ack}, 32'd1);
    check("nomatch_state", {29'd0, dut.state_q}, {29'd0, ST_WAIT_STOP});
    write_byte(8'h5A, -1, ack);
    check("nomatch_state2", {29'd0, dut.state_q}, {29'd0, ST_WAIT_STOP});
    check("nomatch_busy", {31'd0, busy}, 32'd0);
    bus_stop();
    check("nomatch_drive", drv_cnt - drv_base, 32'd0);
    check("nomatch_rx", rx_cnt - rx_base, 32'd0);
    check("nomatch_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});

    // Read two bytes: ACK then NACK
    tx_base = tx_cnt;
    bus_start();
    write_byte(8'h85, -1, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b0, rd);
    check("rd_byte0", {24'd0, rd}, 32'h3C);
    read_byte(1'b1, rd);
    check("rd_byte1", {24'd0, rd}, 32'hC3);
    check("rd_tx_loads", tx_cnt - tx_base, 32'd2);
    check("rd_wait_stop", {29'd0, dut.state_q}, {29'd0, ST_WAIT_STOP});
    bus_stop();
    check("rd_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    check("rd_busy", {31'd0, busy}, 32'd0);

    // Write 0x11, repeated START, read
    tx_base = tx_cnt;
    bus_start();
    write_byte(8'h84, -1, ack);
    check("rs_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h11, -1, ack);
    check("rs_data_ack", {31'd0, ack}, 32'd0);
    check("rs_rx_data", {24'd0, rx_data}, 32'h11);
    bus_start();
    write_byte(8'h85, -1, ack);
    check("rs_raddr_ack", {31'd0, ack}, 32'd0);
    check("rs_tx_load", tx_cnt - tx_base, 32'd1);
    read_byte(1'b1, rd);
    check("rs_rd_byte", {24'd0, rd}, 32'h96);
    bus_stop();

    // Reset during the 4th data bit
    rx_base = rx_cnt;
    bus_start();
    write_byte(8'h84, -1, ack);
    check("rst_addr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 3; i++) write_bit(1'b1, 1'b0);
    m_sda_low = 1'b0; q(1);
    scl = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_sda_released", {31'd0, sda}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    check("rst_busy", {31'd0, busy}, 32'd0);
    q(1);
    scl = 1'b0; q(1);
    for (int i = 0; i < 4; i++) write_bit(1'b0, 1'b0);
    read_bit(ack);
    check("rst_ignored_ack", {31'd0, ack}, 32'd1);
    bus_stop();
    check("rst_no_rx", rx_cnt - rx_base, 32'd0);
    bus_start();
    write_byte(8'h84, -1, ack);
    check("post_rst_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, -1, ack);
    check("post_rst_data_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    check("post_rst_rx_data", {24'd0, rx_data}, 32'h5A);
    check("post_rst_rx_count", rx_cnt - rx_base, 32'd1);

`ifdef I2C_SLAVE_FILTER_EN
    // Single-clock SCL low glitch inside bit 3 must be filtered out
    rx_base = rx_cnt;
    bus_start();
    write_byte(8'h84, -1, ack);
    check("glitch_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'hA5, 3, ack);
    check("glitch_data_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    check("glitch_rx_data", {24'd0, rx_data}, 32'hA5);
    check("glitch_rx_count", rx_cnt - rx_base, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
